// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a one-shot pulse generator that inverts masked bits.
// Optional macro PIO_PULSE_IRQ_EN adds an IRQ enable register at address 6 and drives irq from done.
module avalon_pio_out_pulse #(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_PLEN     = 3'd2;
  localparam logic [2:0] ADDR_PMASK    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [DATA_WIDTH-1:0]      mask_q, mask_d;
  logic [PULSE_CNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       done_q, done_d;

  logic                       wr;
  logic                       busy;
  logic [DATA_WIDTH-1:0]      wd_data;
  logic [PULSE_CNT_WIDTH-1:0] wd_len;
  logic                       unused_wd;

  assign wr        = chipselect & ~write_n;
  assign busy      = (state_q == ST_PULSE);
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_len    = writedata[PULSE_CNT_WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Base value register and its atomic set/clear aliases
  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d = wd_data;
        ADDR_OUTSET:   data_d = data_q | wd_data;
        ADDR_OUTCLEAR: data_d = data_q & ~wd_data;
        default:       data_d = data_q;
      endcase
    end
  end

  always_comb begin
    pulse_len_d = pulse_len_q;
    if (wr && address == ADDR_PLEN) begin
      pulse_len_d = wd_len;
    end
  end

  // Pulse FSM; the done set is evaluated after the W1C so that set wins
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (wr && address == ADDR_STATUS && writedata[1]) begin
      done_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (wr && address == ADDR_PMASK && wd_data != '0 && pulse_len_q != '0) begin
          state_d = ST_PULSE;
          mask_d  = wd_data;
          cnt_d   = pulse_len_q;
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q - PULSE_CNT_WIDTH'(1);
        if (cnt_q == PULSE_CNT_WIDTH'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      data_q      <= RESET_VALUE;
      mask_q      <= '0;
      pulse_len_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      pulse_len_q <= pulse_len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

`ifdef PIO_PULSE_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && address == ADDR_IRQ_EN) begin
      irq_en_d = writedata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end

  assign irq = done_q & irq_en_q;
`else
  assign irq = 1'b0;
`endif

  // Inverted bits only appear while a pulse is running
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
    assign out_port[gi] = data_q[gi] ^ (busy & mask_q[gi]);
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0]      = data_q;
      ADDR_STATUS: readdata[1:0]                 = {done_q, busy};
      ADDR_PLEN:   readdata[PULSE_CNT_WIDTH-1:0] = pulse_len_q;
      ADDR_PMASK:  readdata[DATA_WIDTH-1:0]      = mask_q;
`ifdef PIO_PULSE_IRQ_EN
      ADDR_IRQ_EN: readdata[0]                   = irq_en_q;
`endif
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Scoreboard bench for avalon_pio_out_pulse: stimulus queues expectations, a negedge monitor checks them.
module tb_avalon_pio_out_pulse;

`ifdef PIO_PULSE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  avalon_pio_out_pulse #(
    .DATA_WIDTH     (8),
    .RESET_VALUE    (8'hA5),
    .PULSE_CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {SEL_OUT, SEL_RD, SEL_IRQ} sel_t;
  typedef struct {
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void expect_val(input sel_t sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endfunction

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        SEL_OUT: act = {24'h0, out_port};
        SEL_RD:  act = readdata;
        default: act = {31'h0, irq};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, act);
      end
    end
  end

  task automatic cyc(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d,
                     input logic rn);
    @(posedge clk);
    #1;
    reset_n    = rn;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b1, a, 32'h0, 1'b1);
    expect_val(SEL_RD, exp, name);
  endtask

  task automatic outx(input logic [7:0] exp, input string name);
    expect_val(SEL_OUT, {24'h0, exp}, name);
  endtask

  task automatic irqx(input logic exp, input string name);
    expect_val(SEL_IRQ, {31'h0, exp}, name);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    idle();
    outx(8'hA5, "reset_out");
    irqx(1'b0, "reset_irq");
    rd(3'd0, 32'h0000_00A5, "reset_data");
    rd(3'd1, 32'h0, "reset_status");
    rd(3'd2, 32'h0, "reset_plen");
    rd(3'd3, 32'h0, "reset_mask");

    // DATA / OUTSET / OUTCLEAR
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);  outx(8'h0F, "data_write");
    wr(3'd5, 32'h05);  outx(8'h3F, "outset");
    rd(3'd0, 32'h0000_003A, "outclear_rd"); outx(8'h3A, "outclear");

    // 5-cycle pulse, mask 0x81
    wr(3'd2, 32'd5);
    wr(3'd0, 32'h00);
    wr(3'd3, 32'h81);  outx(8'h00, "p5_before");
    for (int i = 0; i < 5; i++) begin
      rd(3'd1, 32'h1, $sformatf("p5_busy%0d", i));
      outx(8'h81, $sformatf("p5_out%0d", i));
    end
    rd(3'd1, 32'h2, "p5_done");  outx(8'h00, "p5_after");
    rd(3'd3, 32'h81, "p5_mask_rd");
    wr(3'd1, 32'h2);
    rd(3'd1, 32'h0, "w1c_clear");

    // 10-cycle pulse with mid-pulse writes
    wr(3'd2, 32'd10);
    wr(3'd3, 32'h01);  outx(8'h00, "p10_before");
    wr(3'd3, 32'hFF);  outx(8'h01, "p10_c1");
    wr(3'd4, 32'h02);  outx(8'h01, "p10_c2");
    rd(3'd3, 32'h01, "p10_mask_kept"); outx(8'h03, "p10_c3");
    wr(3'd2, 32'd3);   outx(8'h03, "p10_c4");
    for (int i = 5; i <= 10; i++) begin
      idle();
      outx(8'h03, $sformatf("p10_c%0d", i));
    end
    rd(3'd1, 32'h2, "p10_done"); outx(8'h02, "p10_after");
    rd(3'd2, 32'd3, "plen_mid_update");
    wr(3'd1, 32'h2);

    // Ignored pulse starts
    wr(3'd2, 32'd0);
    wr(3'd3, 32'hFF);
    rd(3'd1, 32'h0, "len0_status"); outx(8'h02, "len0_out");
    wr(3'd2, 32'd4);
    wr(3'd3, 32'h00);
    rd(3'd1, 32'h0, "mask0_status"); outx(8'h02, "mask0_out");
    wr(3'd3, 32'h100);
    rd(3'd1, 32'h0, "mask_hi_status"); outx(8'h02, "mask_hi_out");

    // Width handling and write-only / reserved readback
    wr(3'd2, 32'h0001_2345);
    rd(3'd2, 32'h0000_2345, "plen_trunc");
    wr(3'd0, 32'hFFFF_FF02);
    rd(3'd0, 32'h0000_0002, "data_trunc");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'h0, "reserved_rd");
    rd(3'd4, 32'h0, "outset_rd");
    rd(3'd5, 32'h0, "outclear_rd0");

    // Single-cycle pulse
    wr(3'd2, 32'd1);
    wr(3'd3, 32'h80);  outx(8'h02, "p1_before");
    rd(3'd1, 32'h1, "p1_busy"); outx(8'h82, "p1_out");
    rd(3'd1, 32'h2, "p1_done"); outx(8'h02, "p1_after");
    wr(3'd1, 32'h2);

    // Reset in cycle 3 of a 10-cycle pulse
    wr(3'd2, 32'd10);
    wr(3'd3, 32'h0F);  outx(8'h02, "rst_before");
    idle();            outx(8'h0D, "rst_c1");
    idle();            outx(8'h0D, "rst_c2");
    cyc(1'b0, 1'b1, 3'd0, 32'h0, 1'b0); outx(8'h0D, "rst_c3");
    rd(3'd1, 32'h0, "rst_status"); outx(8'hA5, "rst_out");
    rd(3'd3, 32'h0, "rst_mask");

    // IRQ enable, set-wins, W1C
    wr(3'd6, 32'h1);
    rd(3'd6, {31'h0, IRQ_ON}, "irq_en_rd");
    wr(3'd2, 32'd3);
    wr(3'd3, 32'h01);  irqx(1'b0, "irq_before");
    for (int i = 0; i < 3; i++) begin
      idle();
      irqx(1'b0, $sformatf("irq_busy%0d", i));
      outx(8'hA4, $sformatf("irq_out%0d", i));
    end
    idle();            irqx(IRQ_ON, "irq_done");
    wr(3'd3, 32'h01);  irqx(IRQ_ON, "irq_restart");
    idle();
    idle();
    wr(3'd1, 32'h2);   irqx(IRQ_ON, "irq_last");
    rd(3'd1, 32'h2, "set_wins"); irqx(IRQ_ON, "irq_set_wins");
    wr(3'd1, 32'h2);
    rd(3'd1, 32'h0, "final_clear"); irqx(1'b0, "irq_cleared");

    idle();
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
